// File: rtl/tiny_nn_job_arbiter.sv
// Two-requester job arbiter in front of one tiny_nn_top core.
// Buffers whole jobs, replays them gap-free and captures the result.
module tiny_nn_job_arbiter #(
    parameter int unsigned Depth          = 16,
    parameter logic [15:0] TermWord       = 16'h7E00,
    parameter logic [15:0] IdleWord       = 16'h0000,
    parameter int unsigned DrainCycles    = 4,
    parameter int unsigned ResultLoOffset = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    input  logic [31:0] req_data_i,
    input  logic [1:0]  req_last_i,
    output logic [1:0]  req_ready_o,
    output logic [15:0] nn_data_o,
    input  logic [7:0]  nn_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [15:0] rsp_data_o,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);
    localparam int KW = $clog2(DrainCycles + 2);

    localparam logic [AW:0]   FullCnt = (AW + 1)'(Depth);
    localparam logic [KW-1:0] KLast   = KW'(DrainCycles - 1);
    localparam logic [KW-1:0] KLo     = KW'(ResultLoOffset);
    localparam logic [KW-1:0] KHi     = KW'(ResultLoOffset + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_TERM,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       elig;
    logic [1:0][16:0] head;

    logic        owner_q, owner_d;
    logic        last_q;
    logic        pick;
    logic [15:0] nn_d;

    logic          cap_q;
    logic          cap_id_q;
    logic [KW-1:0] ck_q;
    logic [7:0]    lo_q;

    for (genvar n = 0; n < 2; n++) begin : g_fifo
        logic [16:0]   mem [Depth];
        logic [AW:0]   wptr_q;
        logic [AW:0]   rptr_q;
        logic [CW-1:0] jobs_q;
        logic          full;

        assign full           = (wptr_q - rptr_q) == FullCnt;
        assign req_ready_o[n] = !full;
        assign push[n]        = req_valid_i[n] && !full;
        assign pop[n]         = (state_q == S_STREAM) && (owner_q == 1'(n));
        assign head[n]        = mem[rptr_q[AW-1:0]];
        assign elig[n]        = (jobs_q != '0);

        // Word storage; each entry keeps its last flag beside the data.
        always_ff @(posedge clk_i) begin
            if (push[n]) begin
                mem[wptr_q[AW-1:0]] <= {req_last_i[n], req_data_i[16*n +: 16]};
            end
        end

        // Pointers plus count of fully buffered jobs.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                jobs_q <= '0;
            end else begin
                if (push[n]) wptr_q <= wptr_q + (AW + 1)'(1);
                if (pop[n])  rptr_q <= rptr_q + (AW + 1)'(1);
                case ({push[n] && req_last_i[n], pop[n] && head[n][16]})
                    2'b10:   jobs_q <= jobs_q + CW'(1);
                    2'b01:   jobs_q <= jobs_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Round robin: on a tie the requester not granted last wins.
    assign pick = (&elig) ? !last_q : elig[1];

    assign busy_o  = (state_q != S_IDLE);
    assign grant_o = busy_o ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // Next-state and next core word.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        nn_d    = IdleWord;
        unique case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = S_STREAM;
                    owner_d = pick;
                end
            end
            S_STREAM: begin
                nn_d = head[owner_q][15:0];
                if (head[owner_q][16]) state_d = S_TERM;
            end
            S_TERM: begin
                nn_d    = TermWord;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (ck_q == KLast) begin
                    if (|elig) begin
                        state_d = S_STREAM;
                        owner_d = pick;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, owner, grant history and the registered core word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            nn_data_o <= IdleWord;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            nn_data_o <= nn_d;
            if (state_d == S_STREAM) last_q <= owner_d;
        end
    end

    // Drain index runs on its own so the hi byte may land past the drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_q       <= 1'b0;
            cap_id_q    <= 1'b0;
            ck_q        <= '0;
            lo_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (state_q == S_TERM) begin
                cap_q    <= 1'b1;
                cap_id_q <= owner_q;
                ck_q     <= '0;
            end else if (cap_q) begin
                ck_q <= ck_q + KW'(1);
                if (ck_q == KLo) lo_q <= nn_data_i;
                if (ck_q == KHi) begin
                    cap_q       <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_id_o    <= cap_id_q;
                    rsp_data_o  <= {nn_data_i, lo_q};
                end
            end
        end
    end

endmodule

// File: tb/tb_tiny_nn_job_arbiter.sv
// Directed bench for tiny_nn_job_arbiter with a small core model
// and a response scoreboard.
module tb_tiny_nn_job_arbiter;

    localparam logic [15:0] TERM = 16'h7E00;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_valid_i = '0;
    logic [31:0] req_data_i = '0;
    logic [1:0]  req_last_i = '0;
    logic [1:0]  req_ready_o;
    logic [15:0] nn_data_o;
    logic [7:0]  nn_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [15:0] rsp_data_o;
    logic [1:0]  grant_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] core_q[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    tiny_nn_job_arbiter #(
        .Depth(16),
        .TermWord(TERM),
        .IdleWord(IDLE),
        .DrainCycles(4),
        .ResultLoOffset(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .nn_data_o(nn_data_o),
        .nn_data_i(nn_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o),
        .grant_o(grant_o),
        .busy_o(busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Record every response pulse.
    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) got_q.push_back({rsp_id_o, rsp_data_o});
    end

    // Core model: lo byte at drain index 2, hi byte at index 3.
    int          k = 15;
    int          tcnt = 0;
    logic [15:0] cur = '0;
    always @(negedge clk_i) begin
        if (nn_data_o === TERM) begin
            k = 0;
            cur = (tcnt < core_q.size()) ? core_q[tcnt] : 16'h0000;
            tcnt++;
        end else if (k < 15) begin
            k++;
        end
        nn_data_i = (k == 2) ? cur[7:0] : (k == 3) ? cur[15:8] : 8'h00;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input logic [15:0] w, input logic [1:0] g,
                        input string tag);
        @(negedge clk_i);
        chk({tag, ".nn"}, 32'(nn_data_o), 32'(w));
        chk({tag, ".grant"}, 32'(grant_o), 32'(g));
        chk({tag, ".busy"}, 32'(busy_o), 32'(|g));
    endtask

    task automatic push(input int n, input logic [15:0] d, input logic l);
        int w = 0;
        req_valid_i[n] = 1'b1;
        req_data_i[16*n +: 16] = d;
        req_last_i[n] = l;
        while (!req_ready_o[n] && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("push_wait", 32'(w < 200), 32'd1);
        @(negedge clk_i);
        req_valid_i[n] = 1'b0;
        req_last_i[n] = 1'b0;
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk_i);
        chk("rst.nn", 32'(nn_data_o), 32'(IDLE));
        chk("rst.grant", 32'(grant_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.rsp_id", 32'(rsp_id_o), 32'd0);
        chk("rst.rsp_data", 32'(rsp_data_o), 32'd0);
        chk("rst.ready", 32'(req_ready_o), 32'd3);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Both requesters complete at once; req0 first, then req1, then req0.
        core_q.push_back(16'h5A01); exp_q.push_back({1'b0, 16'h5A01});
        core_q.push_back(16'h6B02); exp_q.push_back({1'b1, 16'h6B02});
        core_q.push_back(16'h7C03); exp_q.push_back({1'b0, 16'h7C03});
        push(0, 16'h1100, 1'b0);
        push(1, 16'h2200, 1'b0);
        push(1, 16'h2201, 1'b0);
        req_valid_i = 2'b11;
        req_last_i = 2'b11;
        req_data_i = {16'h2202, 16'h1101};
        @(negedge clk_i);
        req_valid_i = 2'b00;
        req_last_i = 2'b00;
        fork
            begin
                push(0, 16'h3300, 1'b0);
                push(0, 16'h3301, 1'b1);
            end
            begin
                step(IDLE, 2'b01, "rr.a");
                step(16'h1100, 2'b01, "rr.a0");
                step(16'h1101, 2'b01, "rr.a1");
                step(TERM, 2'b01, "rr.at");
                repeat (3) step(IDLE, 2'b01, "rr.ad");
                step(IDLE, 2'b10, "rr.ak4");
                step(16'h2200, 2'b10, "rr.b0");
                step(16'h2201, 2'b10, "rr.b1");
                step(16'h2202, 2'b10, "rr.b2");
                step(TERM, 2'b10, "rr.bt");
                repeat (3) step(IDLE, 2'b10, "rr.bd");
                step(IDLE, 2'b01, "rr.bk4");
                step(16'h3300, 2'b01, "rr.c0");
                step(16'h3301, 2'b01, "rr.c1");
                step(TERM, 2'b01, "rr.ct");
                repeat (3) step(IDLE, 2'b01, "rr.cd");
                step(IDLE, 2'b00, "rr.end");
            end
        join

        // Single three-word job on req0.
        core_q.push_back(16'h3412); exp_q.push_back({1'b0, 16'h3412});
        push(0, 16'h5100, 1'b0);
        push(0, 16'h3C00, 1'b0);
        push(0, 16'h4000, 1'b1);
        step(IDLE, 2'b01, "j1.g");
        step(16'h5100, 2'b01, "j1.w0");
        step(16'h3C00, 2'b01, "j1.w1");
        step(16'h4000, 2'b01, "j1.w2");
        step(TERM, 2'b01, "j1.t");
        repeat (3) step(IDLE, 2'b01, "j1.d");
        step(IDLE, 2'b00, "j1.end");

        // Partial job on req1 must not be granted.
        core_q.push_back(16'h8D04); exp_q.push_back({1'b1, 16'h8D04});
        push(1, 16'h4400, 1'b0);
        push(1, 16'h4401, 1'b0);
        repeat (3) step(IDLE, 2'b00, "part.wait");
        push(1, 16'h4402, 1'b1);
        step(IDLE, 2'b10, "part.g");
        step(16'h4400, 2'b10, "part.w0");
        step(16'h4401, 2'b10, "part.w1");
        step(16'h4402, 2'b10, "part.w2");
        step(TERM, 2'b10, "part.t");
        repeat (3) step(IDLE, 2'b10, "part.d");
        step(IDLE, 2'b00, "part.end");

        // Fill req0 to Depth; the 17th word waits for the first pop.
        core_q.push_back(16'h9E05); exp_q.push_back({1'b0, 16'h9E05});
        core_q.push_back(16'hAF06); exp_q.push_back({1'b0, 16'hAF06});
        for (int i = 0; i < 16; i++) push(0, 16'hA000 + 16'(i), 1'(i == 15));
        chk("full.ready0", 32'(req_ready_o[0]), 32'd0);
        fork
            push(0, 16'hF0F0, 1'b1);
            begin
                step(IDLE, 2'b01, "full.g");
                chk("full.ready1", 32'(req_ready_o[0]), 32'd0);
                step(16'hA000, 2'b01, "full.w0");
                chk("full.ready2", 32'(req_ready_o[0]), 32'd1);
                for (int i = 1; i < 16; i++)
                    step(16'hA000 + 16'(i), 2'b01, "full.w");
                step(TERM, 2'b01, "full.t");
                repeat (4) step(IDLE, 2'b01, "full.d");
                step(16'hF0F0, 2'b01, "full.w16");
                step(TERM, 2'b01, "full.t2");
                repeat (3) step(IDLE, 2'b01, "full.d2");
                step(IDLE, 2'b00, "full.end");
            end
        join

        // Reset at drain index 1 aborts the job; stale req0 word dropped.
        core_q.push_back(16'hDEAD);
        push(0, 16'hEEEE, 1'b0);
        push(1, 16'hB500, 1'b0);
        push(1, 16'hB501, 1'b1);
        step(IDLE, 2'b10, "abort.g");
        step(16'hB500, 2'b10, "abort.w0");
        step(16'hB501, 2'b10, "abort.w1");
        step(TERM, 2'b10, "abort.t");
        step(IDLE, 2'b10, "abort.k1");
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort.nn", 32'(nn_data_o), 32'(IDLE));
        chk("abort.grant", 32'(grant_o), 32'd0);
        chk("abort.busy", 32'(busy_o), 32'd0);
        chk("abort.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort.ready", 32'(req_ready_o), 32'd3);
        repeat (6) step(IDLE, 2'b00, "abort.idle");

        // Single-word job.
        core_q.push_back(16'h5678); exp_q.push_back({1'b0, 16'h5678});
        push(0, 16'hD000, 1'b1);
        step(IDLE, 2'b01, "one.g");
        step(16'hD000, 2'b01, "one.w0");
        step(TERM, 2'b01, "one.t");
        repeat (3) step(IDLE, 2'b01, "one.d");
        step(IDLE, 2'b00, "one.end");

        // Responses against the scoreboard.
        repeat (8) @(negedge clk_i);
        chk("rsp.count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("rsp.item", 32'(got_q[i]), 32'(exp_q[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
